// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares the single-port 80-bit framebuffer memory between
// the VGA scan-out fetches and the Life compute engine.
// - VGA fetches always win; the engine waits behind them on a req/gnt handshake.
// - Owns fb_select. Front buffer = fb_select, back buffer = ~fb_select.
// - A swap requested by the engine is applied only after frame_end, so a
//   displayed frame never mixes two generations.
// Optional build macro FBARB_STALL_CNT_EN adds the eng_stall_cnt output, a
// saturating count of cycles the engine spent waiting.
module fb_mem_arbiter #(
    parameter int DATA_W = 80,
    parameter int OFFS_W = 16,
    parameter int ADDR_W = 40
) (
    input  logic              clk,
    input  logic              rst,
    // VGA fetch port
    input  logic              vga_read,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              frame_end,
    // Engine access port
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic              eng_front,
    input  logic [OFFS_W-1:0] eng_offs,
    input  logic [DATA_W/8-1:0] eng_be,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic [DATA_W-1:0] eng_rdata,
    output logic              eng_rvalid,
    // Buffer swap control
    input  logic              eng_swap_req,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              fb_select,
`ifdef FBARB_STALL_CNT_EN
    output logic [31:0]       eng_stall_cnt,
`endif
    // Memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PAD_W = ADDR_W - OFFS_W - 1;

    // Who owns the read data that the memory returns in the next cycle.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_ENG  = 2'd2
    } tag_t;

    typedef enum logic {
        SW_IDLE = 1'b0,
        SW_PEND = 1'b1
    } swap_state_t;

    swap_state_t       swap_state_reg;
    logic              fb_select_reg;
    logic              swap_pending_reg;
    logic              swap_done_reg;
    tag_t              tag_reg;
    tag_t              tag_next;
    logic [DATA_W-1:0] vga_hold_reg;
    logic [DATA_W-1:0] eng_hold_reg;
    logic              eng_buf;
    logic [ADDR_W-1:0] eng_addr;

    // Writes always target the back buffer; reads may choose either buffer.
    assign eng_buf  = (eng_we || !eng_front) ? ~fb_select_reg : fb_select_reg;
    assign eng_addr = {{PAD_W{1'b0}}, eng_buf, eng_offs};

    // Memory port arbitration: VGA first, then engine unless a swap is pending.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        eng_gnt   = 1'b0;
        tag_next  = TAG_NONE;
        if (!rst) begin
            if (vga_read) begin
                mem_en   = 1'b1;
                mem_be   = '1;
                mem_addr = vga_addr;
                tag_next = TAG_VGA;
            end else if (eng_req && !swap_pending_reg) begin
                eng_gnt   = 1'b1;
                mem_en    = 1'b1;
                mem_we    = eng_we;
                mem_be    = eng_we ? eng_be : {BE_W{1'b1}};
                mem_addr  = eng_addr;
                mem_wdata = eng_wdata;
                tag_next  = eng_we ? TAG_NONE : TAG_ENG;
            end
        end
    end

    // Owner tag for the read issued this cycle; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_reg <= TAG_NONE;
        end else begin
            tag_reg <= tag_next;
        end
    end

    // Hold the last returned word for each requester between returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hold_reg <= '0;
            eng_hold_reg <= '0;
        end else begin
            if (tag_reg == TAG_VGA) begin
                vga_hold_reg <= mem_rdata;
            end
            if (tag_reg == TAG_ENG) begin
                eng_hold_reg <= mem_rdata;
            end
        end
    end

    // Read data is steered straight from memory in the return cycle so the
    // VGA sees exactly one cycle of latency.
    assign vga_data   = (!rst && tag_reg == TAG_VGA) ? mem_rdata : vga_hold_reg;
    assign eng_rdata  = (!rst && tag_reg == TAG_ENG) ? mem_rdata : eng_hold_reg;
    assign eng_rvalid = !rst && (tag_reg == TAG_ENG);

    // Swap FSM: latch the request, apply it at the next frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            swap_state_reg   <= SW_IDLE;
            fb_select_reg    <= 1'b0;
            swap_pending_reg <= 1'b0;
            swap_done_reg    <= 1'b0;
        end else begin
            swap_done_reg <= 1'b0;
            case (swap_state_reg)
                SW_IDLE: begin
                    // A frame_end in the same cycle does not apply this request.
                    if (eng_swap_req) begin
                        swap_state_reg   <= SW_PEND;
                        swap_pending_reg <= 1'b1;
                    end
                end
                SW_PEND: begin
                    // Further swap requests while pending are absorbed.
                    if (frame_end) begin
                        swap_state_reg   <= SW_IDLE;
                        swap_pending_reg <= 1'b0;
                        fb_select_reg    <= ~fb_select_reg;
                        swap_done_reg    <= 1'b1;
                    end
                end
                default: begin
                    swap_state_reg   <= SW_IDLE;
                    swap_pending_reg <= 1'b0;
                end
            endcase
        end
    end

    assign fb_select    = fb_select_reg;
    assign swap_pending = swap_pending_reg;
    assign swap_done    = swap_done_reg;

`ifdef FBARB_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Count cycles the engine is requesting but not granted; saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (eng_req && !eng_gnt && stall_cnt_reg != 32'hFFFF_FFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign eng_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Self-checking bench for fb_mem_arbiter: a vector table for the memory port
// mux, a read-return scoreboard, and hand sequences for reset and buffer swaps.
module tb_fb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_read;
    logic [39:0] vga_addr;
    logic [79:0] vga_data;
    logic        frame_end;
    logic        eng_req;
    logic        eng_we;
    logic        eng_front;
    logic [15:0] eng_offs;
    logic [9:0]  eng_be;
    logic [79:0] eng_wdata;
    logic        eng_gnt;
    logic [79:0] eng_rdata;
    logic        eng_rvalid;
    logic        eng_swap_req;
    logic        swap_pending;
    logic        swap_done;
    logic        fb_select;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_be;
    logic [39:0] mem_addr;
    logic [79:0] mem_wdata;
    logic [79:0] mem_rdata = '0;
`ifdef FBARB_STALL_CNT_EN
    logic [31:0] eng_stall_cnt;
`endif

    fb_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .vga_read     (vga_read),
        .vga_addr     (vga_addr),
        .vga_data     (vga_data),
        .frame_end    (frame_end),
        .eng_req      (eng_req),
        .eng_we       (eng_we),
        .eng_front    (eng_front),
        .eng_offs     (eng_offs),
        .eng_be       (eng_be),
        .eng_wdata    (eng_wdata),
        .eng_gnt      (eng_gnt),
        .eng_rdata    (eng_rdata),
        .eng_rvalid   (eng_rvalid),
        .eng_swap_req (eng_swap_req),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .fb_select    (fb_select),
`ifdef FBARB_STALL_CNT_EN
        .eng_stall_cnt(eng_stall_cnt),
`endif
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic        vga_read;
        logic [39:0] vga_addr;
        logic        req;
        logic        we;
        logic        front;
        logic [15:0] offs;
        logic [9:0]  be;
        logic        exp_en;
        logic        exp_we;
        logic        exp_gnt;
        logic [39:0] exp_addr;
        logic [9:0]  exp_be;
    } vec_t;

    typedef struct {
        int          due;
        bit          is_eng;
        logic [79:0] data;
    } sb_t;

    sb_t sb[$];

    // Memory content is a fixed function of the address.
    function automatic logic [79:0] mem_fn(input logic [39:0] a);
        return {a, a ^ 40'hA5A5_5A5A_C3};
    endfunction

    function automatic vec_t mk(input logic v, input logic [39:0] va, input logic r,
                                input logic w, input logic f, input logic [15:0] o,
                                input logic [9:0] b, input logic xen, input logic xwe,
                                input logic xg, input logic [39:0] xa, input logic [9:0] xb);
        vec_t t;
        t.vga_read = v;  t.vga_addr = va; t.req = r; t.we = w; t.front = f;
        t.offs = o; t.be = b; t.exp_en = xen; t.exp_we = xwe; t.exp_gnt = xg;
        t.exp_addr = xa; t.exp_be = xb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single-memory model: read data appears the cycle after the access.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en && !mem_we) mem_rdata <= mem_fn(mem_addr);
    end

    // Scoreboard: compare returns due this cycle, flag unexpected rvalid.
    always @(negedge clk) begin
        sb_t e;
        bit  eng_seen;
        eng_seen = 1'b0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk("sb_stale_due", 80'(e.due), 80'(cyc));
            end else if (e.is_eng) begin
                eng_seen = 1'b1;
                chk("eng_rvalid", eng_rvalid, 1'b1);
                chk("eng_rdata", eng_rdata, e.data);
                $display("ret  cyc=%0d eng data=%h", cyc, eng_rdata);
            end else begin
                chk("vga_data", vga_data, e.data);
                $display("ret  cyc=%0d vga data=%h", cyc, vga_data);
            end
        end
        if (eng_rvalid && !eng_seen) chk("eng_rvalid_spurious", eng_rvalid, 1'b0);
    end

    // Drive one vector, check the same-cycle memory port, queue any read return.
    task automatic apply(input vec_t v, input string tag);
        logic [95:0] wd;
        wd = {$urandom, $urandom, $urandom};
        vga_read  = v.vga_read;
        vga_addr  = v.vga_addr;
        eng_req   = v.req;
        eng_we    = v.we;
        eng_front = v.front;
        eng_offs  = v.offs;
        eng_be    = v.be;
        eng_wdata = wd[79:0];
        #2;
        chk({tag, ".mem_en"}, mem_en, v.exp_en);
        chk({tag, ".eng_gnt"}, eng_gnt, v.exp_gnt);
        if (v.exp_en) begin
            chk({tag, ".mem_we"}, mem_we, v.exp_we);
            chk({tag, ".mem_addr"}, mem_addr, v.exp_addr);
            if (v.exp_gnt) chk({tag, ".mem_be"}, mem_be, v.exp_be);
            if (v.exp_gnt && v.exp_we) chk({tag, ".mem_wdata"}, mem_wdata, eng_wdata);
            if (!v.exp_we) begin
                sb_t e;
                e.due = cyc + 1;
                e.is_eng = v.exp_gnt;
                e.data = mem_fn(v.exp_addr);
                sb.push_back(e);
            end
        end
        $display("txn  %s cyc=%0d en=%0b we=%0b gnt=%0b addr=%h", tag, cyc, mem_en, mem_we,
                 eng_gnt, mem_addr);
        next_cycle();
    endtask

    task automatic idle_inputs();
        vga_read = 0; vga_addr = '0; eng_req = 0; eng_we = 0; eng_front = 0;
        eng_offs = '0; eng_be = '0; eng_wdata = '0; frame_end = 0; eng_swap_req = 0;
    endtask

    vec_t tbl[12];
    vec_t tbl1[3];

    initial begin
        // mk(vga, vga_addr, req, we, front, offs, be, exp_en, exp_we, exp_gnt, exp_addr, exp_be)
        tbl[0]  = mk(0, 40'h0,       0, 0, 0, 16'h0000, 10'h000, 0, 0, 0, 40'h0,       10'h000);
        tbl[1]  = mk(1, 40'h0_0105,  1, 0, 0, 16'h0105, 10'h000, 1, 0, 0, 40'h0_0105,  10'h000);
        tbl[2]  = mk(0, 40'h0,       1, 0, 0, 16'h0105, 10'h000, 1, 0, 1, 40'h1_0105,  10'h3FF);
        tbl[3]  = mk(0, 40'h0,       1, 0, 1, 16'h00AB, 10'h000, 1, 0, 1, 40'h0_00AB,  10'h3FF);
        tbl[4]  = mk(0, 40'h0,       1, 1, 0, 16'h1234, 10'h3FF, 1, 1, 1, 40'h1_1234,  10'h3FF);
        tbl[5]  = mk(0, 40'h0,       1, 1, 1, 16'h1234, 10'h0F0, 1, 1, 1, 40'h1_1234,  10'h0F0);
        tbl[6]  = mk(1, 40'h1_7777,  1, 1, 0, 16'h1234, 10'h3FF, 1, 0, 0, 40'h1_7777,  10'h000);
        tbl[7]  = mk(0, 40'h0,       1, 0, 0, 16'h0001, 10'h000, 1, 0, 1, 40'h1_0001,  10'h3FF);
        tbl[8]  = mk(0, 40'h0,       1, 0, 0, 16'h0002, 10'h000, 1, 0, 1, 40'h1_0002,  10'h3FF);
        tbl[9]  = mk(1, 40'h0_FF00,  0, 0, 0, 16'h0000, 10'h000, 1, 0, 0, 40'h0_FF00,  10'h000);
        tbl[10] = mk(0, 40'h0,       1, 1, 0, 16'hFFFF, 10'h001, 1, 1, 1, 40'h1_FFFF,  10'h001);
        tbl[11] = mk(0, 40'h0,       0, 0, 0, 16'h0000, 10'h000, 0, 0, 0, 40'h0,       10'h000);
        // Same accesses with fb_select = 1.
        tbl1[0] = mk(0, 40'h0,       1, 0, 1, 16'h0005, 10'h000, 1, 0, 1, 40'h1_0005,  10'h3FF);
        tbl1[1] = mk(0, 40'h0,       1, 0, 0, 16'h0005, 10'h000, 1, 0, 1, 40'h0_0005,  10'h3FF);
        tbl1[2] = mk(0, 40'h0,       1, 1, 1, 16'h0005, 10'h3FF, 1, 1, 1, 40'h0_0005,  10'h3FF);

        idle_inputs();
        rst = 1;
        next_cycle();
        next_cycle();
        chk("rst.mem_en", mem_en, 1'b0);
        chk("rst.eng_gnt", eng_gnt, 1'b0);
        rst = 0;
        #2;
        chk("rst.fb_select", fb_select, 1'b0);
        chk("rst.swap_pending", swap_pending, 1'b0);
        chk("rst.swap_done", swap_done, 1'b0);
        chk("rst.eng_rvalid", eng_rvalid, 1'b0);
        chk("rst.mem_we", mem_we, 1'b0);
        chk("rst.mem_be", mem_be, 10'h000);
        chk("rst.vga_data", vga_data, 80'h0);
        chk("rst.eng_rdata", eng_rdata, 80'h0);
        next_cycle();

        for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Swap request, held 40 cycles, then frame_end.
        vga_read = 0; eng_req = 1; eng_we = 1; eng_front = 0; eng_offs = 16'h1234;
        eng_be = 10'h3FF; eng_swap_req = 1;
        #2;
        chk("swap.req_cycle_gnt", eng_gnt, 1'b1);
        chk("swap.req_cycle_pending", swap_pending, 1'b0);
        next_cycle();
        eng_swap_req = 0;
        for (int i = 0; i < 39; i++) begin
            #2;
            chk("swap.pending", swap_pending, 1'b1);
            chk("swap.gnt_blocked", eng_gnt, 1'b0);
            chk("swap.mem_en_idle", mem_en, 1'b0);
            next_cycle();
        end
        frame_end = 1;
        #2;
        chk("swap.fe_pending", swap_pending, 1'b1);
        chk("swap.fe_gnt", eng_gnt, 1'b0);
        chk("swap.fe_fb_select", fb_select, 1'b0);
        next_cycle();
        frame_end = 0;
        #2;
        chk("swap.fb_select", fb_select, 1'b1);
        chk("swap.swap_done", swap_done, 1'b1);
        chk("swap.pending_clr", swap_pending, 1'b0);
        chk("swap.gnt_resume", eng_gnt, 1'b1);
        chk("swap.write_back_addr", mem_addr, 40'h0_1234);
        $display("txn  swap cyc=%0d fb_select=%0b swap_done=%0b", cyc, fb_select, swap_done);
        next_cycle();
        eng_req = 0;
        frame_end = 1;
        #2;
        chk("swap.done_pulse", swap_done, 1'b0);
        next_cycle();
        frame_end = 0;
        #2;
        chk("swap.idle_fe_no_toggle", fb_select, 1'b1);
        next_cycle();

        for (int i = 0; i < 3; i++) apply(tbl1[i], $sformatf("fb1_vec%0d", i));

`ifdef FBARB_STALL_CNT_EN
        begin
            logic [31:0] base;
            base = eng_stall_cnt;
            vga_read = 1; vga_addr = 40'h0_0010; eng_req = 1; eng_we = 1;
            repeat (5) next_cycle();
            vga_read = 0; eng_req = 0;
            #2;
            chk("stall_cnt", eng_stall_cnt, base + 32'd5);
            next_cycle();
        end
`endif

        // Reset in the middle of an engine read: no return may appear.
        idle_inputs();
        eng_req = 1; eng_we = 0; eng_front = 0; eng_offs = 16'h0003;
        #2;
        chk("midrst.gnt", eng_gnt, 1'b1);
        next_cycle();
        rst = 1;
        eng_req = 0;
        #2;
        chk("midrst.rvalid_in_rst", eng_rvalid, 1'b0);
        chk("midrst.mem_en_in_rst", mem_en, 1'b0);
        next_cycle();
        next_cycle();
        rst = 0;
        #2;
        chk("midrst.fb_select", fb_select, 1'b0);
        chk("midrst.mem_en", mem_en, 1'b0);
        chk("midrst.eng_gnt", eng_gnt, 1'b0);
        chk("midrst.eng_rvalid", eng_rvalid, 1'b0);
        $display("txn  midrst cyc=%0d fb_select=%0b rvalid=%0b", cyc, fb_select, eng_rvalid);
        next_cycle();

        // Coincident swap request and frame_end: swap waits one more frame.
        eng_swap_req = 1; frame_end = 1;
        next_cycle();
        eng_swap_req = 0; frame_end = 0;
        #2;
        chk("coinc.fb_select_held", fb_select, 1'b0);
        chk("coinc.pending", swap_pending, 1'b1);
        chk("coinc.no_done", swap_done, 1'b0);
        next_cycle();
        eng_swap_req = 1;
        next_cycle();
        eng_swap_req = 0;
        next_cycle();
        #2;
        chk("coinc.still_held", fb_select, 1'b0);
        frame_end = 1;
        next_cycle();
        frame_end = 0;
        #2;
        chk("coinc.fb_select", fb_select, 1'b1);
        chk("coinc.swap_done", swap_done, 1'b1);
        chk("coinc.pending_clr", swap_pending, 1'b0);
        $display("txn  coinc cyc=%0d fb_select=%0b swap_done=%0b", cyc, fb_select, swap_done);
        next_cycle();
        frame_end = 1;
        next_cycle();
        frame_end = 0;
        #2;
        chk("coinc.single_toggle", fb_select, 1'b1);

        repeat (3) next_cycle();
        chk("sb.drain", 80'(sb.size()), 80'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
